// File: rtl/result_packer_if.sv
// result_packer_if: controller/adder-facing capture, consume and status signals of the result packer.
interface result_packer_if #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int CNT_W         = 16
);
  logic                     buffer_write;
  logic                     buffer_control;
  logic [DATA_W-1:0]        sum_i;
  logic                     carry_i;
  logic                     write;
  logic                     clear_i;
  logic [MEM_WORD_SIZE-1:0] buff_result;
  logic                     word_ready;
  logic [1:0]               half_valid;
  logic [1:0]               carry_flags;
  logic [CNT_W-1:0]         overflow_cnt;
  logic [CNT_W-1:0]         words_packed;
  logic                     overwrite_err;
  logic                     underflow_err;
  modport master (
    output buffer_write, buffer_control, sum_i, carry_i, write, clear_i,
    input  buff_result, word_ready, half_valid, carry_flags, overflow_cnt, words_packed,
           overwrite_err, underflow_err
  );
  modport slave (
    input  buffer_write, buffer_control, sum_i, carry_i, write, clear_i,
    output buff_result, word_ready, half_valid, carry_flags, overflow_cnt, words_packed,
           overwrite_err, underflow_err
  );
endinterface

// File: rtl/result_packer.sv
// result_packer: packs two 32-bit adder sums into one 64-bit SRAM word with
// half-validity tracking, carry capture, statistics and sticky protocol errors.
module result_packer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64,
  parameter int CNT_W         = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  result_packer_if.slave bus
);
  typedef enum logic [1:0] {EMPTY = 2'b00, LOW = 2'b01, HIGH = 2'b10, FULL = 2'b11} state_t;
  state_t             state, state_nxt;
  logic [DATA_W-1:0]  upper_q, lower_q;
  logic [1:0]         carry_q;
  logic [CNT_W-1:0]   ovf_q, words_q;
  logic               ovw_q, und_q;
  logic               cap, con;
  logic [1:0]         sel_bit;
  assign cap     = ~bus.buffer_write;
  assign con     = ~bus.write;
  assign sel_bit = bus.buffer_control ? 2'b10 : 2'b01;
  // A consume empties the word before a same-cycle capture lands in it.
  always_comb state_nxt = con ? (cap ? state_t'(sel_bit) : EMPTY)
                              : (cap ? state_t'(state | sel_bit) : state);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= EMPTY;
      upper_q <= '0;
      lower_q <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      words_q <= '0;
      ovw_q   <= 1'b0;
      und_q   <= 1'b0;
    end else if (bus.clear_i) begin
      state   <= EMPTY;
      upper_q <= '0;
      lower_q <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
      words_q <= '0;
      ovw_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap && bus.buffer_control) begin
        upper_q    <= bus.sum_i;
        carry_q[1] <= bus.carry_i;
      end
      if (cap && !bus.buffer_control) begin
        lower_q    <= bus.sum_i;
        carry_q[0] <= bus.carry_i;
      end
      if (cap && bus.carry_i && !(&ovf_q)) ovf_q <= ovf_q + CNT_W'(1);
      if (con && state == FULL) words_q <= words_q + CNT_W'(1);
      if (con && state != FULL) und_q <= 1'b1;
      if (cap && !con && |(state & sel_bit)) ovw_q <= 1'b1;
    end
  end
  assign bus.buff_result   = {upper_q, lower_q};
  assign bus.half_valid    = state;
  assign bus.word_ready    = state == FULL;
  assign bus.carry_flags   = carry_q;
  assign bus.overflow_cnt  = ovf_q;
  assign bus.words_packed  = words_q;
  assign bus.overwrite_err = ovw_q;
  assign bus.underflow_err = und_q;
endmodule
